mmio_timer: RTL and testbench

Memory-mapped timer peripheral responding in the 0x80001xxx window selected by the system address decoder's active-low timer chip select. It provides a prescaled 32-bit up-counter, a compare register with a sticky match flag, optional auto-reload and a level interrupt. Reads return registered data one cycle after the access, and the block drives zero otherwise so its data can be OR-combined with other peripherals on the CPU load path.

---
 rtl/timer_pkg.sv | 42 ++++
 rtl/timer_prescaler.sv | 27 ++
 rtl/mmio_timer.sv | 120 ++++++++++++
 tb/tb_mmio_timer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants, control register layout and byte-enable helper for the mmio_timer peripheral.
package timer_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PRESC_W = 16;
    localparam int unsigned BE_W    = DATA_W / 8;

    localparam int unsigned TMR_CTRL_OFS  = 32'h000;
    localparam int unsigned TMR_COUNT_OFS = 32'h004;
    localparam int unsigned TMR_CMP_OFS   = 32'h008;
    localparam int unsigned TMR_STAT_OFS  = 32'h00C;
    localparam int unsigned TMR_PRESC_OFS = 32'h010;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_AR_BIT    = 1;
    localparam int unsigned CTRL_IRQEN_BIT = 2;
    localparam int unsigned CTRL_W         = 3;
    localparam int unsigned STAT_MATCH_BIT = 0;

    localparam logic [DATA_W-1:0] COMPARE_RST = 32'hFFFF_FFFF;

    // Field order mirrors CTRL bit positions (en is bit 0).
    typedef struct packed {
        logic irqen;
        logic autoreload;
        logic en;
    } ctrl_t;

    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter: issues one tick every presc+1 enabled cycles; held at zero while disabled.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt;

    assign tick = en & (pcnt == presc);

    // pcnt wraps at all-ones if presc was lowered below it while running.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer with compare/match, auto-reload and level irq.
// Optional prescaler and PRESCALE register are built when TIMER_PRESCALE_EN is defined.
module mmio_timer
    import timer_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic [31:0]       rdata,
    output logic              irq
);

    ctrl_t              ctrl_q, ctrl_d;
    logic [DATA_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0]  cmp_q, cmp_d;
    logic               match_q, match_d;
    logic               irq_q, irq_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               tick, hit;
    logic               wr, rd;
    logic [ADDR_W-1:0]  word;
    logic               sel_ctrl, sel_count, sel_cmp, sel_stat;

    assign wr   = !cs_n &  we;
    assign rd   = !cs_n & !we;
    assign word = addr & ~ADDR_W'(3);

    assign sel_ctrl  = (word == ADDR_W'(TMR_CTRL_OFS));
    assign sel_count = (word == ADDR_W'(TMR_COUNT_OFS));
    assign sel_cmp   = (word == ADDR_W'(TMR_CMP_OFS));
    assign sel_stat  = (word == ADDR_W'(TMR_STAT_OFS));

`ifdef TIMER_PRESCALE_EN
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               sel_presc;

    assign sel_presc = (word == ADDR_W'(TMR_PRESC_OFS));

    timer_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl_q.en),
        .presc (presc_q),
        .tick  (tick)
    );
`else
    assign tick = ctrl_q.en;
`endif

    assign hit = tick & (count_q == cmp_q);

    // Next-state: CPU writes beat the tick update of COUNT; a new match beats W1C.
    always_comb begin
        ctrl_d  = ctrl_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        match_d = match_q;
        rdata_d = '0;
`ifdef TIMER_PRESCALE_EN
        presc_d = presc_q;
`endif
        if (tick) begin
            count_d = (hit && ctrl_q.autoreload) ? '0 : count_q + DATA_W'(1);
        end
        if (wr) begin
            if (sel_ctrl && be[0]) ctrl_d = ctrl_t'(wdata[CTRL_W-1:0]);
            if (sel_count)         count_d = be_merge(count_q, wdata, be);
            if (sel_cmp)           cmp_d = be_merge(cmp_q, wdata, be);
            if (sel_stat && be[0] && wdata[STAT_MATCH_BIT]) match_d = 1'b0;
`ifdef TIMER_PRESCALE_EN
            if (sel_presc) presc_d = PRESC_W'(be_merge(DATA_W'(presc_q), wdata, be));
`endif
        end
        if (hit) match_d = 1'b1;
        if (rd) begin
            if (sel_ctrl)       rdata_d = DATA_W'(ctrl_q);
            else if (sel_count) rdata_d = count_q;
            else if (sel_cmp)   rdata_d = cmp_q;
            else if (sel_stat)  rdata_d = DATA_W'(match_q);
`ifdef TIMER_PRESCALE_EN
            else if (sel_presc) rdata_d = DATA_W'(presc_q);
`endif
        end
        irq_d = match_d & ctrl_d.irqen;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            count_q <= '0;
            cmp_q   <= COMPARE_RST;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
`ifdef TIMER_PRESCALE_EN
            presc_q <= '0;
`endif
        end else begin
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
`ifdef TIMER_PRESCALE_EN
            presc_q <= presc_d;
`endif
        end
    end

    assign rdata = rdata_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: register table plus timed count/match/priority sequences.
module tb_mmio_timer;

`ifdef TIMER_PRESCALE_EN
    localparam bit HAS_PRESC = 1'b1;
`else
    localparam bit HAS_PRESC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs_n = 1'b1;
    logic        we = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic [31:0] rdata;
    logic        irq;

    always #5 clk = ~clk;

    mmio_timer #(.ADDR_W(12)) dut (
        .clk   (clk),
        .reset (reset),
        .cs_n  (cs_n),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .be    (be),
        .rdata (rdata),
        .irq   (irq)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: expected read data queued at issue, popped when rdata is due.
    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;
    sb_t sbq[$];

    logic rd_flag = 1'b0;
    logic mon_en  = 1'b0;

    always @(posedge clk) rd_flag <= !cs_n && !we && !reset;

    always @(negedge clk) begin
        sb_t e;
        if (mon_en) begin
            if (rd_flag) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_empty: got 0x%08h expected no read", rdata);
                end else begin
                    e = sbq.pop_front();
                    chk(e.name, rdata, e.exp);
                end
            end else begin
                chk("rdata_idle", rdata, 32'h0);
            end
        end
    end

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
        cs_n = 1'b0; we = 1'b1; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        cs_n = 1'b1; we = 1'b0; be = '0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e, input string n);
        sb_t s;
        s.exp = e;
        s.name = n;
        sbq.push_back(s);
        cs_n = 1'b0; we = 1'b0; addr = a;
        @(posedge clk); #1;
        cs_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vt[$];

    function automatic void add(input logic w, input logic [11:0] a, input logic [31:0] d,
                                input logic [3:0] b, input logic [31:0] e, input string n);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.be = b; v.exp = e; v.name = n;
        vt.push_back(v);
    endfunction

    initial begin
        add(0, 12'h000, 0, 0, 32'h0,        "ctrl_rst");
        add(0, 12'h004, 0, 0, 32'h0,        "count_rst");
        add(0, 12'h008, 0, 0, 32'hFFFFFFFF, "cmp_rst");
        add(0, 12'h00C, 0, 0, 32'h0,        "stat_rst");
        add(0, 12'h010, 0, 0, 32'h0,        "presc_rst");
        add(1, 12'h008, 32'hAABBCCDD, 4'b0010, 0, "");
        add(0, 12'h008, 0, 0, 32'hFFFFCCFF, "cmp_be");
        add(1, 12'h020, 32'h12345678, 4'hF, 0, "");
        add(0, 12'h020, 0, 0, 32'h0,        "unmapped_rd");
        add(0, 12'h000, 0, 0, 32'h0,        "ctrl_after_unmapped");
        add(0, 12'h00B, 0, 0, 32'hFFFFCCFF, "cmp_low_bits_ignored");
        add(1, 12'h010, 32'h0001ABCD, 4'hF, 0, "");
        add(0, 12'h010, 0, 0, HAS_PRESC ? 32'h0000ABCD : 32'h0, "presc_rw");
        add(1, 12'h010, 32'h0, 4'hF, 0, "");
        add(1, 12'h000, 32'hFFFFFFF8, 4'hF, 0, "");
        add(0, 12'h000, 0, 0, 32'h0,        "ctrl_rsvd");
        add(1, 12'h000, 32'h7, 4'h0, 0, "");
        add(0, 12'h000, 0, 0, 32'h0,        "ctrl_be0");
        add(1, 12'h004, 32'h12345678, 4'b1100, 0, "");
        add(0, 12'h004, 0, 0, 32'h12340000, "count_be");
        add(1, 12'h004, 32'h0, 4'hF, 0, "");
        add(1, 12'h008, 32'hFFFFFFFF, 4'hF, 0, "");
        add(0, 12'h008, 0, 0, 32'hFFFFFFFF, "cmp_restore");

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        chk("irq_rst", 32'(irq), 32'h0);

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].we) wr(vt[i].addr, vt[i].wdata, vt[i].be);
            else          rd(vt[i].addr, vt[i].exp, vt[i].name);
        end

        // Basic count, prescale 0
        wr(12'h000, 32'h1, 4'hF);
        idle(9);
        rd(12'h004, 32'd9, "count_a");
        idle(4);
        rd(12'h004, 32'd14, "count_b");
        wr(12'h000, 32'h0, 4'hF);
        rd(12'h004, 32'd16, "count_stop");

        // Match with autoreload and irq
        wr(12'h004, 32'h0, 4'hF);
        wr(12'h008, 32'h3, 4'hF);
        wr(12'h000, 32'h7, 4'hF);
        for (int i = 1; i <= 5; i++) begin
            idle(1);
            chk("irq_match_seq", 32'(irq), (i >= 4) ? 32'h1 : 32'h0);
        end
        rd(12'h00C, 32'h1, "stat_match");
        wr(12'h000, 32'h6, 4'hF);
        rd(12'h004, 32'd3, "count_reload");
        chk("irq_held", 32'(irq), 32'h1);
        wr(12'h00C, 32'h1, 4'hF);
        chk("irq_w1c", 32'(irq), 32'h0);
        rd(12'h00C, 32'h0, "stat_cleared");

        // Match set coinciding with W1C: set wins
        wr(12'h000, 32'h7, 4'hF);
        wr(12'h00C, 32'h1, 4'hF);
        chk("irq_set_wins", 32'(irq), 32'h1);
        wr(12'h000, 32'h0, 4'hF);
        rd(12'h00C, 32'h1, "stat_set_wins");
        rd(12'h004, 32'd1, "count_after_reload");
        wr(12'h00C, 32'h1, 4'hF);
        rd(12'h00C, 32'h0, "stat_clr2");
        chk("irq_off", 32'(irq), 32'h0);

        // COUNT write on a tick/match cycle
        wr(12'h004, 32'd5, 4'hF);
        wr(12'h008, 32'd5, 4'hF);
        wr(12'h000, 32'h1, 4'hF);
        wr(12'h004, 32'h100, 4'hF);
        rd(12'h004, 32'h100, "count_wr_wins");
        wr(12'h000, 32'h0, 4'hF);
        rd(12'h004, 32'h102, "count_after_wr");
        rd(12'h00C, 32'h1, "stat_match_on_wr");
        wr(12'h00C, 32'h1, 4'hF);

        // Wrap sets nothing
        wr(12'h004, 32'hFFFFFFFE, 4'hF);
        wr(12'h000, 32'h1, 4'hF);
        idle(1);
        wr(12'h000, 32'h0, 4'hF);
        rd(12'h004, 32'h0, "count_wrap");
        rd(12'h00C, 32'h0, "stat_wrap");

        // Prescale 4
        wr(12'h004, 32'h0, 4'hF);
        wr(12'h010, 32'h4, 4'hF);
        wr(12'h000, 32'h1, 4'hF);
        idle(12);
        rd(12'h004, HAS_PRESC ? 32'd2 : 32'd12, "count_presc_a");
        wr(12'h000, 32'h0, 4'hF);
        rd(12'h004, HAS_PRESC ? 32'd2 : 32'd14, "count_presc_b");
        rd(12'h010, HAS_PRESC ? 32'd4 : 32'd0, "presc_rd");
        wr(12'h010, 32'h0, 4'hF);

        // Reset mid-operation with a read in flight
        wr(12'h004, 32'h0, 4'hF);
        wr(12'h008, 32'h0, 4'hF);
        wr(12'h000, 32'h5, 4'hF);
        idle(2);
        chk("irq_pre_reset", 32'(irq), 32'h1);
        reset = 1'b1; cs_n = 1'b0; we = 1'b0; addr = 12'h000;
        @(posedge clk); #1;
        reset = 1'b0; cs_n = 1'b1;
        chk("irq_post_reset", 32'(irq), 32'h0);
        rd(12'h000, 32'h0, "ctrl_post_reset");
        rd(12'h004, 32'h0, "count_post_reset");
        rd(12'h008, 32'hFFFFFFFF, "cmp_post_reset");
        rd(12'h00C, 32'h0, "stat_post_reset");

        idle(3);
        if (sbq.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
